// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NUM_REQ systolic PEs.
// Define ARB_TIMEOUT_EN to add a watchdog that aborts a stuck multiply with result_err.
module mult_share_arbiter #(
  parameter int WORDLENGTH     = 16,
  parameter int NUM_REQ        = 8,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic                          clk30x,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*WORDLENGTH-1:0] opa_bus,
  input  logic [NUM_REQ*WORDLENGTH-1:0] opb_bus,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [WORDLENGTH-1:0]         result,
  output logic [NUM_REQ-1:0]            result_valid,
  output logic                          result_err,
  output logic [WORDLENGTH-1:0]         mult_a,
  output logic [WORDLENGTH-1:0]         mult_b,
  output logic                          mult_start,
  input  logic                          mult_busy,
  input  logic [WORDLENGTH-1:0]         mult_result
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    RETURN
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       last_granted;
  logic [IDX_W-1:0]       rr_idx;
  logic                   rr_found;
  logic [SUM_W-1:0]       rr_cand;
  logic [WORDLENGTH-1:0]  opa_w [NUM_REQ];
  logic [WORDLENGTH-1:0]  opb_w [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign opa_w[i] = opa_bus[i*WORDLENGTH +: WORDLENGTH];
    assign opb_w[i] = opb_bus[i*WORDLENGTH +: WORDLENGTH];
  end

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Walk candidates from farthest to nearest so the one just after last_granted wins.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rr_idx   = last_granted;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_cand = SUM_W'(last_granted) + SUM_W'(k);
      if (rr_cand >= SUM_W'(NUM_REQ)) rr_cand = rr_cand - SUM_W'(NUM_REQ);
      if (req[rr_cand[IDX_W-1:0]]) begin
        rr_idx   = rr_cand[IDX_W-1:0];
        rr_found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
  assign wd_hit = (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign result_err = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk30x) begin
    if (reset) begin
      state        <= IDLE;
      last_granted <= LAST_IDX;
      gnt          <= '0;
      result_valid <= '0;
      result       <= '0;
      mult_start   <= 1'b0;
      mult_a       <= '0;
      mult_b       <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt       <= '0;
      result_err   <= 1'b0;
`endif
    end else begin
      mult_start   <= 1'b0;
      result_valid <= '0;
      case (state)
        IDLE: begin
          if (rr_found) begin
            // Operands are frozen here and held until the transaction retires.
            last_granted <= rr_idx;
            gnt          <= onehot(rr_idx);
            mult_a       <= opa_w[rr_idx];
            mult_b       <= opb_w[rr_idx];
            mult_start   <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (mult_busy) state <= WAIT_DONE;
`ifdef ARB_TIMEOUT_EN
          wd_cnt <= wd_cnt + 1'b1;
          if (wd_hit && !mult_busy) begin
            result       <= '0;
            result_err   <= 1'b1;
            result_valid <= onehot(last_granted);
            state        <= RETURN;
          end
`endif
        end
        WAIT_DONE: begin
          if (!mult_busy) begin
            result       <= mult_result;
            result_valid <= onehot(last_granted);
            state        <= RETURN;
          end
`ifdef ARB_TIMEOUT_EN
          wd_cnt <= wd_cnt + 1'b1;
          if (wd_hit && mult_busy) begin
            result       <= '0;
            result_err   <= 1'b1;
            result_valid <= onehot(last_granted);
            state        <= RETURN;
          end
`endif
        end
        RETURN: begin
          gnt   <= '0;
          state <= IDLE;
`ifdef ARB_TIMEOUT_EN
          result_err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a behavioural sequential multiplier
// and a requester model that drops req after its result_valid.
module tb_mult_share_arbiter;

  localparam int W = 16;
  localparam int N = 8;

  logic           clk30x;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] opa_bus;
  logic [N*W-1:0] opb_bus;
  logic [N-1:0]   gnt;
  logic [W-1:0]   result;
  logic [N-1:0]   result_valid;
  logic           result_err;
  logic [W-1:0]   mult_a;
  logic [W-1:0]   mult_b;
  logic           mult_start;
  logic           mult_busy;
  logic [W-1:0]   mult_result;

  mult_share_arbiter #(.WORDLENGTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(63)) dut (
    .clk30x      (clk30x),
    .reset       (reset),
    .req         (req),
    .opa_bus     (opa_bus),
    .opb_bus     (opb_bus),
    .gnt         (gnt),
    .result      (result),
    .result_valid(result_valid),
    .result_err  (result_err),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_start  (mult_start),
    .mult_busy   (mult_busy),
    .mult_result (mult_result)
  );

  initial begin
    clk30x = 1'b0;
    forever #5 clk30x = ~clk30x;
  end

  // Sequential multiplier: busy rises after mult_start and stays high busy_len cycles.
  int         busy_len;
  int         busy_cnt;
  logic       stuck;
  logic [W-1:0] prod;
  logic [31:0]  prod_full;
  assign prod_full = 32'(mult_a) * 32'(mult_b);

  always @(posedge clk30x) begin
    if (reset) begin
      mult_busy   <= 1'b0;
      busy_cnt    <= 0;
      mult_result <= '0;
      prod        <= '0;
    end else if (mult_start) begin
      mult_busy <= 1'b1;
      busy_cnt  <= busy_len;
      prod      <= prod_full[W-1:0];
    end else if (mult_busy && !stuck) begin
      if (busy_cnt <= 1) begin
        mult_busy   <= 1'b0;
        mult_result <= prod;
      end else begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  typedef struct {
    int           pe;
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  int starts  = 0;
  int rv_cnt  = 0;
  int rv_cycle = 0;
  int onehot_err = 0;
  int stab_err = 0;
  logic         stab_mode = 1'b0;
  logic [W-1:0] stab_a, stab_b;
  logic [N-1:0] gnt_seen;
  logic [W-1:0] start_a, start_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    opa_bus[i*W +: W] = a;
    opb_bus[i*W +: W] = b;
  endtask

  task automatic push(input int i);
    exp_t e;
    logic [31:0] p;
    p     = 32'(opa_bus[i*W +: W]) * 32'(opb_bus[i*W +: W]);
    e.pe  = i;
    e.res = p[W-1:0];
    e.err = 1'b0;
    sb.push_back(e);
  endtask

  // One clock: observe at the falling edge, score results, and act as the requesters.
  task automatic step();
    exp_t e;
    @(negedge clk30x);
    cycle++;
    if (mult_start) begin
      starts++;
      start_a = mult_a;
      start_b = mult_b;
    end
    if ($countones(gnt) > 1) onehot_err++;
    if (gnt != '0 && gnt_seen == '0) gnt_seen = gnt;
    if (stab_mode && gnt != '0) begin
      if (mult_a !== stab_a || mult_b !== stab_b) stab_err++;
      opa_bus[3*W +: W] = W'($urandom);
      opb_bus[3*W +: W] = W'($urandom);
      req = '0;
    end
    if (result_valid != '0) begin
      rv_cnt++;
      rv_cycle = cycle;
      if (sb.size() == 0) begin
        check("unexpected_result_valid", 32'(result_valid), 32'h0);
      end else begin
        e = sb.pop_front();
        check("result_valid", 32'(result_valid), 32'(oh(e.pe)));
        check("result", 32'(result), 32'(e.res));
        check("result_err", 32'(result_err), 32'(e.err));
      end
      req = req & ~result_valid;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'h0);
    step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    req   = '0;
    sb.delete();
    repeat (n) step();
    reset = 1'b0;
  endtask

  int t0, s0, r0, n;

  initial begin
    reset = 1'b1; req = '0; opa_bus = '0; opb_bus = '0;
    stuck = 1'b0; busy_len = 30; gnt_seen = '0;
    repeat (3) step();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_result_valid", 32'(result_valid), 32'h0);
    check("rst_result_err", 32'(result_err), 32'h0);
    check("rst_mult_start", 32'(mult_start), 32'h0);
    check("rst_mult_a", 32'(mult_a), 32'h0);
    check("rst_mult_b", 32'(mult_b), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    reset = 1'b0;
    step();

    // Single request on PE0: 3*5 with a 30-cycle multiply.
    set_ops(0, 16'd3, 16'd5);
    gnt_seen = '0; s0 = starts; t0 = cycle;
    req = 8'h01; push(0);
    drain(100);
    check("single_starts", 32'(starts - s0), 32'd1);
    check("single_gnt", 32'(gnt_seen), 32'h01);
    check("single_mult_a", 32'(start_a), 32'd3);
    check("single_mult_b", 32'(start_b), 32'd5);
    // req cycle, ISSUE, 30 busy cycles (first overlaps WAIT_START), capture, RETURN.
    check("single_latency", 32'(rv_cycle - t0), 32'(busy_len + 3));

    // All requesters at once after reset: PE0..PE7 in order, then wrap to PE0 before PE7.
    do_reset(2);
    busy_len = 3;
    for (int i = 0; i < N - 1; i++) set_ops(i, W'($urandom), W'($urandom));
    set_ops(N - 1, 16'hFFFF, 16'hFFFF);
    req = 8'hFF;
    for (int i = 0; i < N; i++) push(i);
    drain(300);
    req = 8'h81; push(0); push(7);
    drain(100);

    // Fairness after wrap: last served PE6, then 0x41 serves PE0 first.
    set_ops(6, 16'd1234, 16'd7);
    req = 8'h40; push(6);
    drain(100);
    set_ops(0, 16'd250, 16'd260);
    req = 8'h41; push(0); push(6);
    drain(100);

    // Operand scramble and req drop while PE3 is granted.
    set_ops(3, 16'd321, 16'd99);
    stab_a = 16'd321; stab_b = 16'd99; stab_err = 0; s0 = starts;
    busy_len = 8;
    req = 8'h08; push(3);
    stab_mode = 1'b1;
    drain(100);
    stab_mode = 1'b0;
    check("stability_mult_ab", 32'(stab_err), 32'h0);
    check("dropped_req_starts", 32'(starts - s0), 32'd1);

    // Reset while waiting for the multiplier, then a fresh PE2 request.
    busy_len = 20;
    set_ops(1, 16'd11, 16'd13);
    req = 8'h02; push(1);
    n = 0;
    while (!mult_busy && n < 10) begin
      step();
      n++;
    end
    check("rst_mid_busy_seen", 32'(mult_busy), 32'h1);
    repeat (3) step();
    reset = 1'b1; req = '0; sb.delete(); r0 = rv_cnt;
    step();
    check("rst_mid_gnt", 32'(gnt), 32'h0);
    check("rst_mid_result_valid", 32'(result_valid), 32'h0);
    reset = 1'b0;
    repeat (40) step();
    check("rst_mid_no_result", 32'(rv_cnt - r0), 32'h0);
    busy_len = 5;
    set_ops(2, 16'd40000, 16'd3);
    req = 8'h04; push(2);
    drain(100);

    // Multiplier stuck busy on PE5.
    stuck = 1'b1;
    set_ops(5, 16'd9, 16'd9);
    r0 = rv_cnt;
    req = 8'h20;
`ifdef ARB_TIMEOUT_EN
    begin
      exp_t e;
      e.pe = 5; e.res = '0; e.err = 1'b1;
      sb.push_back(e);
    end
    drain(200);
`else
    repeat (100) step();
    check("stuck_no_result", 32'(rv_cnt - r0), 32'h0);
    check("stuck_gnt_held", 32'(gnt), 32'h20);
`endif
    stuck = 1'b0;
    do_reset(2);

    // No requests: nothing starts.
    s0 = starts; r0 = rv_cnt;
    repeat (20) step();
    check("idle_no_start", 32'(starts - s0), 32'h0);
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_no_result", 32'(rv_cnt - r0), 32'h0);

    check("gnt_onehot", 32'(onehot_err), 32'h0);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
